pipeline_stall_ctrl: RTL and testbench
======================================

// Module: pipeline_stall_ctrl
// PURPOSE
//  Stall/flush sequencer for the 5-stage pipeline, alongside the EX-stage forwarding unit.
//  Detects load-use hazards forwarding cannot cover, flushes on taken branches, and freezes
//  the pipeline while data memory is busy. Drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB enables and flushes.
// PARAMETERS
//  MEM_TIMEOUT  16  MEM_WAIT cycles before mem_timeout is raised (>=1)
//  CNT_W        32  width of the statistics counters (STALL_STATS_EN only)
// PORTS
//  clk              in   1      single clock, rising edge
//  rst              in   1      synchronous reset, active-high
//  id_rs1, id_rs2   in   5      source register indices of the instruction in ID
//  id_uses_rs2      in   1      ID instruction reads rs2
//  ex_memread       in   1      EX instruction is a load
//  ex_rd            in   5      destination register of the EX instruction
//  ex_branch_taken  in   1      branch/jump resolved taken in EX
//  dmem_req         in   1      MEM stage has an access outstanding
//  dmem_ack         in   1      data memory completes the access this cycle
//  pc_write         out  1      PC register enable
//  ifid_write       out  1      IF/ID register enable
//  ifid_flush       out  1      IF/ID loads a NOP
//  idex_flush       out  1      ID/EX loads a bubble (control bits zero)
//  pipe_adv         out  1      EX/MEM and MEM/WB register enable
//  mem_timeout      out  1      sticky: a memory wait exceeded MEM_TIMEOUT
//  stall_cycles     out  CNT_W  cycles with pc_write=0
//  flush_count      out  CNT_W  taken-branch flushes applied
// BEHAVIOUR
//  - Reset: state=RUN, wait counter=0, mem_timeout=0, counters=0. While rst=1, outputs are
//    pc_write=ifid_write=pipe_adv=1 and both flushes 0.
//  - FSM states: RUN, MEM_WAIT. Outputs are combinational from state and inputs (0-cycle latency).
//  - RUN -> MEM_WAIT when dmem_req=1 and dmem_ack=0. In that cycle all enables are 0 and
//    both flushes are 0 (full freeze). A req with ack in the same cycle causes no stall.
//  - MEM_WAIT and ack=0: full freeze; the wait counter increments. When the counter reaches
//    MEM_TIMEOUT, mem_timeout sets (sticky until rst); the FSM keeps waiting.
//  - MEM_WAIT and ack=1: the cycle is evaluated as a RUN cycle (below); next state is RUN;
//    the wait counter clears.
//  - RUN cycle priority, highest first:
//    1. Memory freeze (above).
//    2. Taken branch: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, pipe_adv=1.
//       This overrides a load-use hazard, because the ID instruction is discarded.
//    3. Load-use: the hazard holds when ex_memread=1, ex_rd!=0, and either ex_rd==id_rs1 or
//       (id_uses_rs2=1 and ex_rd==id_rs2).
//       Response: pc_write=0, ifid_write=0, idex_flush=1, pipe_adv=1. Lasts exactly one
//       cycle, since the load leaves EX.
//    4. Otherwise: all enables 1, flushes 0.
//  - A branch or hazard present during a freeze is held by the frozen registers and is
//    applied on the ack cycle.
//  - The r0 destination never causes a stall.
// CONFIGURATION
//  - PIPELINE_STALL_STATS_EN defined:
//    - stall_cycles increments on every non-reset cycle with pc_write=0.
//    - flush_count increments on every applied taken-branch flush.
//    - Both counters saturate at all-ones.
//  - Not defined: stall_cycles and flush_count are tied to 0 and no counter flops exist.
//    Ports are unchanged.
// STRUCTURE
//  - Package pipeline_ctrl_pkg holds:
//    - state enum {RUN, MEM_WAIT};
//    - REG_IDX_W=5 and REG_ZERO=5'd0;
//    - localparam WAIT_CNT_W = $clog2(MEM_TIMEOUT+1).
//  - One sub-module, pipeline_stall_stats: the two saturating counters, instantiated only
//    under PIPELINE_STALL_STATS_EN.
// TESTING
//  1. Load-use: ex_memread=1, ex_rd=5, id_rs1=5 -> one cycle of pc_write=0, ifid_write=0,
//     idex_flush=1; the next cycle (ex_memread=0) is normal.
//  2. Hazard masks: ex_rd=0 with id_rs1=0 -> no stall. ex_rd=7, id_rs2=7, id_uses_rs2=0
//     -> no stall.
//  3. Branch over hazard: ex_branch_taken=1 together with a load-use match -> ifid_flush=1,
//     idex_flush=1, pc_write=1.
//  4. Memory wait: dmem_req=1 with ack low for 3 cycles, ack on the 4th -> 3 frozen cycles
//     (pipe_adv=0), advance on the 4th, state RUN after.
//  5. Timeout (MEM_TIMEOUT=4): hold req without ack for 6 cycles -> mem_timeout rises after
//     4 MEM_WAIT cycles and stays 1 after ack; rst clears it.
//  6. Stats (with the macro): tests 1 and 4 -> stall_cycles=4; test 3 -> flush_count=1.
//     Assert rst mid-wait -> RUN, counters 0 next cycle.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Package name pipeline_ctrl_pkg; imported by the interface, the top and the stats block.
// Contents: controller state enum, register-index constants, wait-counter width helper.
package pipeline_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  localparam int unsigned MEM_TIMEOUT_DFLT = 16;

  // Width needed to hold a wait count of 0..timeout inclusive.
  function automatic int unsigned wait_cnt_w(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the stall controller.
// master : pipeline side, drives ID/EX/MEM hazard info, receives enables/flushes/status.
// slave  : controller side (pipeline_stall_ctrl).
// Signals: id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd, ex_branch_taken, dmem_req, dmem_ack
//          pc_write, ifid_write, ifid_flush, idex_flush, pipe_adv, mem_timeout,
//          stall_cycles[CNT_W], flush_count[CNT_W]
interface pipeline_stall_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);

  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_uses_rs2;
  logic                 ex_memread;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_branch_taken;
  logic                 dmem_req;
  logic                 dmem_ack;

  logic                 pc_write;
  logic                 ifid_write;
  logic                 ifid_flush;
  logic                 idex_flush;
  logic                 pipe_adv;
  logic                 mem_timeout;
  logic [CNT_W-1:0]     stall_cycles;
  logic [CNT_W-1:0]     flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd, ex_branch_taken,
           dmem_req, dmem_ack,
    input  pc_write, ifid_write, ifid_flush, idex_flush, pipe_adv, mem_timeout,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_memread, ex_rd, ex_branch_taken,
           dmem_req, dmem_ack,
    output pc_write, ifid_write, ifid_flush, idex_flush, pipe_adv, mem_timeout,
           stall_cycles, flush_count
  );

endinterface

// File: rtl/pipeline_stall_stats.sv
// Saturating statistics counters for the stall controller.
// Only instantiated when PIPELINE_STALL_STATS_EN is defined.
// Ports: clk, rst (sync, active-high), stall_inc_i, flush_inc_i,
//        stall_cycles_o[CNT_W], flush_count_o[CNT_W]
module pipeline_stall_stats
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc_i,
  input  logic             flush_inc_i,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_inc_i && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (flush_inc_i && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_count_o  = flush_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Detects load-use hazards, flushes IF/ID and ID/EX on taken branches, freezes the whole
// pipeline while data memory is busy, and flags over-long memory waits.
// Optional feature macro: PIPELINE_STALL_STATS_EN (stall/flush statistics counters).
// Ports: clk, rst (sync, active-high), bus (pipeline_stall_ctrl_if.slave).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; hazards/branches resolved combinationally
// MEM_WAIT | data memory access outstanding, pipeline frozen until ack
module pipeline_stall_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DFLT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_stall_ctrl_if.slave  bus
);

  localparam int unsigned WAIT_CNT_W = wait_cnt_w(MEM_TIMEOUT);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_TIMEOUT);

  ctrl_state_e           state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                  timeout_q, timeout_d;

  logic freeze;
  logic load_use;

  // A frozen cycle: a new miss in RUN, or still no ack while waiting.
  assign freeze = bus.dmem_ack ? 1'b0 :
                  ((state_q == MEM_WAIT) || bus.dmem_req);

  assign load_use = bus.ex_memread && (bus.ex_rd != REG_ZERO) &&
                    ((bus.ex_rd == bus.id_rs1) ||
                     (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    unique case (state_q)
      RUN: begin
        if (bus.dmem_req && !bus.dmem_ack) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (bus.dmem_ack) begin
          state_d = RUN;
        end else begin
          // Saturate so a very long wait cannot wrap the counter.
          wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q
                                                   : wait_cnt_q + WAIT_CNT_W'(1);
          if (wait_cnt_d == WAIT_LIMIT) timeout_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    bus.pc_write   = 1'b1;
    bus.ifid_write = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.idex_flush = 1'b0;
    bus.pipe_adv   = 1'b1;
    if (!rst) begin
      if (freeze) begin
        bus.pc_write   = 1'b0;
        bus.ifid_write = 1'b0;
        bus.pipe_adv   = 1'b0;
      end else if (bus.ex_branch_taken) begin
        // The ID instruction is discarded, so any load-use match is moot.
        bus.ifid_flush = 1'b1;
        bus.idex_flush = 1'b1;
      end else if (load_use) begin
        bus.pc_write   = 1'b0;
        bus.ifid_write = 1'b0;
        bus.idex_flush = 1'b1;
      end
    end
  end

  assign bus.mem_timeout = timeout_q;

`ifdef PIPELINE_STALL_STATS_EN
  logic [CNT_W-1:0] stall_cycles_w;
  logic [CNT_W-1:0] flush_count_w;

  pipeline_stall_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk            (clk),
    .rst            (rst),
    .stall_inc_i    (!rst && !bus.pc_write),
    .flush_inc_i    (!rst && bus.ifid_flush),
    .stall_cycles_o (stall_cycles_w),
    .flush_count_o  (flush_count_w)
  );

  assign bus.stall_cycles = stall_cycles_w;
  assign bus.flush_count  = flush_count_w;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned MEM_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_adv}
  logic [4:0] ctl;
  assign ctl = {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_flush, bus.pipe_adv};

  localparam logic [4:0] NORM   = 5'b11001;
  localparam logic [4:0] FREEZE = 5'b00000;
  localparam logic [4:0] LDUSE  = 5'b00011;
  localparam logic [4:0] BRANCH = 5'b11111;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_uses_rs2 = 1'b0;
    bus.ex_memread = 1'b0; bus.ex_rd = '0; bus.ex_branch_taken = 1'b0;
    bus.dmem_req = 1'b0; bus.dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
    bus.dmem_req = 1'b1;
    rst = 1'b1;
    step(); step();
    n_cmp++;
    if (ctl !== NORM) begin n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, NORM); end
    n_cmp++;
    if (bus.mem_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", bus.mem_timeout); end
    n_cmp++;
    if (bus.stall_cycles !== '0 || bus.flush_count !== '0) begin
      n_err++; $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.stall_cycles, bus.flush_count);
    end
    idle();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== NORM) begin n_err++; $display("FAIL post_reset_ctl: got %b want %b", ctl, NORM); end
    step();
  endtask

  task automatic test_load_use();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
    #1;
    n_cmp++;
    if (ctl !== LDUSE) begin n_err++; $display("FAIL load_use: got %b want %b", ctl, LDUSE); end
    step();
    bus.ex_memread = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== NORM) begin n_err++; $display("FAIL load_use_after: got %b want %b", ctl, NORM); end
    step();
    idle();
  endtask

  task automatic test_branch_over_hazard();
    bus.ex_branch_taken = 1'b1;
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
    #1;
    n_cmp++;
    if (ctl !== BRANCH) begin n_err++; $display("FAIL branch_hazard: got %b want %b", ctl, BRANCH); end
    step();
    idle();
    #1;
    n_cmp++;
    if (ctl !== NORM) begin n_err++; $display("FAIL branch_after: got %b want %b", ctl, NORM); end
    step();
  endtask

  task automatic test_mem_wait();
    bus.dmem_req = 1'b1; bus.dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ctl !== FREEZE) begin n_err++; $display("FAIL mem_wait_freeze%0d: got %b want %b", i, ctl, FREEZE); end
      step();
    end
    bus.dmem_ack = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== NORM) begin n_err++; $display("FAIL mem_wait_ack: got %b want %b", ctl, NORM); end
    step();
    idle();
    #1;
    n_cmp++;
    if (ctl !== NORM || bus.mem_timeout !== 1'b0) begin
      n_err++; $display("FAIL mem_wait_run: got %b/%b want %b/0", ctl, bus.mem_timeout, NORM);
    end
    step();
  endtask

  task automatic test_stats(input int exp_stall, input int exp_flush, input string tag);
    logic [CNT_W-1:0] es, ef;
`ifdef PIPELINE_STALL_STATS_EN
    es = CNT_W'(exp_stall);
    ef = CNT_W'(exp_flush);
`else
    es = '0;
    ef = '0;
`endif
    n_cmp++;
    if (bus.stall_cycles !== es) begin n_err++; $display("FAIL stats_stall_%s: got %0d want %0d", tag, bus.stall_cycles, es); end
    n_cmp++;
    if (bus.flush_count !== ef) begin n_err++; $display("FAIL stats_flush_%s: got %0d want %0d", tag, bus.flush_count, ef); end
  endtask

  task automatic test_hazard_masks();
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0;
    #1;
    n_cmp++;
    if (ctl !== NORM) begin n_err++; $display("FAIL mask_r0: got %b want %b", ctl, NORM); end
    step();
    bus.ex_rd = 5'd7; bus.id_rs1 = 5'd3; bus.id_rs2 = 5'd7; bus.id_uses_rs2 = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== NORM) begin n_err++; $display("FAIL mask_rs2_unused: got %b want %b", ctl, NORM); end
    bus.id_uses_rs2 = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== LDUSE) begin n_err++; $display("FAIL rs2_used: got %b want %b", ctl, LDUSE); end
    step();
    idle();
  endtask

  task automatic test_freeze_priority();
    bus.dmem_req = 1'b1; bus.ex_branch_taken = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== FREEZE) begin n_err++; $display("FAIL freeze_over_branch: got %b want %b", ctl, FREEZE); end
    step();
    bus.dmem_ack = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== BRANCH) begin n_err++; $display("FAIL branch_on_ack: got %b want %b", ctl, BRANCH); end
    step();
    idle();
    bus.dmem_req = 1'b1;
    bus.ex_memread = 1'b1; bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9;
    #1;
    n_cmp++;
    if (ctl !== FREEZE) begin n_err++; $display("FAIL freeze_over_hazard: got %b want %b", ctl, FREEZE); end
    step();
    bus.dmem_ack = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== LDUSE) begin n_err++; $display("FAIL hazard_on_ack: got %b want %b", ctl, LDUSE); end
    step();
    idle();
  endtask

  task automatic test_timeout();
    bus.dmem_req = 1'b1; bus.dmem_ack = 1'b0;
    // Cycle 0 enters MEM_WAIT; cycles 1..5 are MEM_WAIT; flag visible from cycle 5.
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if (ctl !== FREEZE || bus.mem_timeout !== (i >= 5)) begin
        n_err++; $display("FAIL timeout_cycle%0d: got %b/%b want %b/%b", i, ctl, bus.mem_timeout, FREEZE, (i >= 5));
      end
      step();
    end
    bus.dmem_ack = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== NORM || bus.mem_timeout !== 1'b1) begin
      n_err++; $display("FAIL timeout_ack: got %b/%b want %b/1", ctl, bus.mem_timeout, NORM);
    end
    step();
    idle();
    #1;
    n_cmp++;
    if (bus.mem_timeout !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: got %b want 1", bus.mem_timeout); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.mem_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_rst_clear: got %b want 0", bus.mem_timeout); end
    step();
  endtask

  task automatic test_reset_mid_wait();
    bus.dmem_req = 1'b1;
    step(); step();
    #1;
    n_cmp++;
    if (ctl !== FREEZE) begin n_err++; $display("FAIL midwait_freeze: got %b want %b", ctl, FREEZE); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== NORM) begin n_err++; $display("FAIL midwait_rst_ctl: got %b want %b", ctl, NORM); end
    step();
    rst = 1'b0;
    idle();
    #1;
    n_cmp++;
    if (ctl !== NORM) begin n_err++; $display("FAIL midwait_run: got %b want %b", ctl, NORM); end
    n_cmp++;
    if (bus.stall_cycles !== '0 || bus.flush_count !== '0) begin
      n_err++; $display("FAIL midwait_counters: got %0d/%0d want 0/0", bus.stall_cycles, bus.flush_count);
    end
    step();
  endtask

  initial begin
    idle();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_branch_over_hazard();
    test_mem_wait();
    test_stats(4, 1, "basic");
    test_hazard_masks();
    test_freeze_priority();
    test_stats(8, 2, "freeze");
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
